// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter and single-transaction
// sequencer for one shared memory port with acknowledge and watchdog.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_width,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_width,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dout,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [1:0]  mem_width,
  input  logic [31:0] mem_din,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
  } req_t;

  localparam int unsigned   CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_V    = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t          state, state_nxt;
  req_t [1:0]      req_in;
  req_t            req_q;
  logic [1:0]      req_v;
  logic [1:0]      gnt;
  logic            win;
  logic            owner;
  logic            last_grant;
  logic            err_q;
  logic            timed_out;
  logic [CW-1:0]   cnt;
  logic [1:0][31:0] rdata_q;

  assign req_in[0] = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, width: m0_width};
  assign req_in[1] = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, width: m1_width};
  assign req_v     = {m1_req, m0_req};

  // Width 3 is reserved; half and word accesses must be naturally aligned.
  function automatic logic legal(input req_t r);
    case (r.width)
      2'd0:    legal = 1'b1;
      2'd1:    legal = ~r.addr[0];
      2'd2:    legal = (r.addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  endfunction

  // Round-robin pick: a tie goes to whoever was not granted last.
  always_comb begin
    win = (&req_v) ? ~last_grant : req_v[1];
  end

  // Watchdog fires only when the memory has not answered in the final allowed cycle.
  assign timed_out = (TIMEOUT != 0) && (cnt == TO_V) && !mem_ack;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and all outputs; everything is forced low while reset is held.
  always_comb begin
    state_nxt    = state;
    gnt          = 2'b00;
    m0_done      = 1'b0;
    m1_done      = 1'b0;
    m0_err       = 1'b0;
    m1_err       = 1'b0;
    mem_addr     = '0;
    mem_dout     = '0;
    mem_width    = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE: begin
        if ((|req_v) && !reset) begin
          gnt[win]  = 1'b1;
          state_nxt = legal(req_in[win]) ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        if (!reset) begin
          mem_addr     = req_q.addr;
          mem_dout     = req_q.wdata;
          mem_width    = req_q.width;
          mem_read_en  = ~req_q.we;
          mem_write_en = req_q.we;
        end
        if (mem_ack || timed_out) state_nxt = RESP;
      end
      RESP: begin
        if (!reset) begin
          m0_done = ~owner;
          m1_done = owner;
          m0_err  = ~owner & err_q;
          m1_err  = owner & err_q;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_gnt   = gnt[0];
  assign m1_gnt   = gnt[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];

  // Request latch, ownership, watchdog counter, error flag and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      err_q      <= 1'b0;
      cnt        <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_v) begin
            req_q      <= req_in[win];
            owner      <= win;
            last_grant <= win;
            err_q      <= ~legal(req_in[win]);
            cnt        <= '0;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            err_q <= 1'b0;
            if (!req_q.we) rdata_q[owner] <= mem_din;
          end else begin
            if (timed_out)      err_q <= 1'b1;
            if (cnt != CNT_MAX) cnt   <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mem_bus_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  m0_width, m1_width;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        mem_read_en, mem_write_en, mem_ack;
  logic [1:0]  mem_width;

  mem_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_width(m0_width),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_width(m1_width),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_width(mem_width), .mem_din(mem_din), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  // Acks after ws wait states when ack_en; spur drives ack while no strobe is up.
  int          ws = 0;
  bit          ack_en = 1'b1;
  bit          spur = 1'b0;
  logic [31:0] din_v = '0;
  int          scnt = 0;

  always @(posedge clk) begin
    #2;
    if (mem_read_en || mem_write_en) begin
      mem_ack = ack_en && (scnt == ws);
      scnt++;
    end else begin
      mem_ack = spur;
      scnt = 0;
    end
    mem_din = din_v;
  end

  // ---------------- reference model + compare ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    int          o;
    bit          legal;
  } txn_t;

  txn_t        tx;
  bit          busy = 1'b0;
  bit          mlast = 1'b1;
  int          t0, endc;
  bit          ok;
  logic [31:0] mrd [2] = '{32'h0, 32'h0};

  always @(negedge clk) begin
    bit [1:0]    eg, ed, ee;
    bit          estb, upd;
    logic [31:0] updv;
    int          k, w;
    eg = '0; ed = '0; ee = '0; estb = 1'b0; upd = 1'b0; updv = '0;
    if (reset) begin
      busy = 1'b0;
      mlast = 1'b1;
    end else if (!busy) begin
      if (m0_req || m1_req) begin
        w = (m0_req && m1_req) ? int'(!mlast) : int'(m1_req);
        eg[w] = 1'b1;
        mlast = w[0];
        tx.o     = w;
        tx.we    = (w == 0) ? m0_we    : m1_we;
        tx.addr  = (w == 0) ? m0_addr  : m1_addr;
        tx.wdata = (w == 0) ? m0_wdata : m1_wdata;
        tx.width = (w == 0) ? m0_width : m1_width;
        tx.legal = (tx.width != 2'd3) && ((tx.addr % (32'd1 << tx.width)) == 0);
        busy = 1'b1;
        t0 = cyc;
        endc = -1;
      end
    end else begin
      k = cyc - t0;
      if (!tx.legal) begin
        if (k == 1) begin ed[tx.o] = 1'b1; ee[tx.o] = 1'b1; busy = 1'b0; end
      end else if (endc < 0) begin
        estb = 1'b1;
        if (mem_ack) begin
          endc = cyc; ok = 1'b1;
          if (!tx.we) begin upd = 1'b1; updv = mem_din; end
        end else if (TO != 0 && k - 1 == TO) begin
          endc = cyc; ok = 1'b0;
        end
      end else begin
        ed[tx.o] = 1'b1; ee[tx.o] = !ok; busy = 1'b0;
      end
    end
    chk("m0_gnt", m0_gnt, eg[0]);
    chk("m1_gnt", m1_gnt, eg[1]);
    chk("m0_done", m0_done, ed[0]);
    chk("m1_done", m1_done, ed[1]);
    chk("m0_err", m0_err, ee[0]);
    chk("m1_err", m1_err, ee[1]);
    chk("mem_read_en", mem_read_en, estb && !tx.we);
    chk("mem_write_en", mem_write_en, estb && tx.we);
    chk("mem_addr", mem_addr, estb ? tx.addr : 32'h0);
    chk("mem_dout", mem_dout, estb ? tx.wdata : 32'h0);
    chk("mem_width", {30'h0, mem_width}, estb ? {30'h0, tx.width} : 32'h0);
    if (!reset) begin
      chk("m0_rdata", m0_rdata, mrd[0]);
      chk("m1_rdata", m1_rdata, mrd[1]);
    end else begin
      mrd[0] = '0; mrd[1] = '0;
    end
    if (upd) mrd[tx.o] = updv;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Raise a request, wait for its grant (bounded), drop it the next cycle.
  // Returns the grant cycle and how many cycles the request waited.
  task automatic issue(input int m, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] w, output int tg, output int waited);
    tick();
    if (m == 0) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = wd; m0_width = w; end
    else        begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = wd; m1_width = w; end
    tg = -1; waited = 0;
    for (int i = 0; i < 50; i++) begin
      #3;
      if ((m == 0) ? m0_gnt : m1_gnt) begin
        tg = cyc;
        tick();
        if (m == 0) m0_req = 0; else m1_req = 0;
        return;
      end
      waited++;
      tick();
    end
    checks++; errors++;
    $display("FAIL grant_timeout: master %0d got no grant in 50 cycles", m);
    m0_req = 0; m1_req = 0;
  endtask

  // Count strobe cycles until master m sees done (bounded); report latency from grant.
  task automatic run_to_done(input int m, input int tg, output int n, output int d,
                             output logic e, output logic [31:0] rd);
    n = 0; d = -1; e = 1'bx; rd = 'x;
    for (int i = 0; i < 30; i++) begin
      #3;
      if (mem_read_en || mem_write_en) n++;
      if ((m == 0) ? m0_done : m1_done) begin
        d  = cyc - tg;
        e  = (m == 0) ? m0_err : m1_err;
        rd = (m == 0) ? m0_rdata : m1_rdata;
        return;
      end
      tick();
    end
    checks++; errors++;
    $display("FAIL done_timeout: master %0d saw no done in 30 cycles", m);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int tg, wt, n, d, g0, g1;
    logic e;
    logic [31:0] rd;
    reset = 1; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; m0_width = 0; m1_width = 0;
    mem_ack = 0; mem_din = 0;
    repeat (3) tick();
    #3;
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_mem_read_en", mem_read_en, 1'b0);
    tick(); reset = 0;

    // Zero-wait read on m0.
    ws = 0; din_v = 32'hDEADBEEF;
    issue(0, 0, 32'h100, 0, 2, tg, wt);
    chk("rd_gnt_wait", wt, 0);
    #3;
    chk("rd_strobe_T1", mem_read_en, 1'b1);
    chk("rd_addr_T1", mem_addr, 32'h100);
    tick(); #3;
    chk("rd_done_T2", m0_done, 1'b1);
    chk("rd_err_T2", m0_err, 1'b0);
    chk("rd_rdata_T2", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_done", m1_done, 1'b0);
    chk("rd_m1_rdata", m1_rdata, 32'h0);

    // Both masters continuously requesting: grants alternate, starting with m1.
    tick();
    m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'h11; m0_width = 2;
    m1_req = 1; m1_we = 0; m1_addr = 32'h80; m1_width = 2;
    g0 = 0; g1 = 0;
    for (int i = 0; i < 15; i++) begin
      din_v = 32'h5A5A0000 + i;
      #3;
      g0 += int'(m0_gnt); g1 += int'(m1_gnt);
      tick();
    end
    m0_req = 0; m1_req = 0;
    chk("rr_m0_grants", g0, 2);
    chk("rr_m1_grants", g1, 3);
    repeat (3) tick();

    // Misaligned half write and reserved width: error at T+1, no strobe.
    issue(1, 1, 32'h203, 32'h55, 1, tg, wt);
    #3;
    chk("mis_done_T1", m1_done, 1'b1);
    chk("mis_err_T1", m1_err, 1'b1);
    chk("mis_no_strobe", mem_write_en, 1'b0);
    issue(1, 0, 32'h0, 0, 3, tg, wt);
    #3;
    chk("w3_done_T1", m1_done, 1'b1);
    chk("w3_err_T1", m1_err, 1'b1);

    // Watchdog: write with no ack, then read with no ack, then ack on the last allowed cycle.
    ack_en = 0;
    issue(0, 1, 32'h300, 32'h77, 2, tg, wt);
    run_to_done(0, tg, n, d, e, rd);
    chk("to_wr_strobes", n, 5);
    chk("to_wr_latency", d, 6);
    chk("to_wr_err", e, 1'b1);
    din_v = 32'hBAADF00D;
    issue(0, 0, 32'h304, 0, 2, tg, wt);
    run_to_done(0, tg, n, d, e, rd);
    chk("to_rd_err", e, 1'b1);
    chk("to_rd_rdata_held", rd, 32'hDEADBEEF);
    ack_en = 1; ws = 4; din_v = 32'h12345678;
    issue(0, 0, 32'h308, 0, 2, tg, wt);
    run_to_done(0, tg, n, d, e, rd);
    chk("edge_strobes", n, 5);
    chk("edge_latency", d, 6);
    chk("edge_err", e, 1'b0);
    chk("edge_rdata", rd, 32'h12345678);

    // Reset in the middle of a waiting access.
    ws = 10;
    issue(1, 0, 32'h400, 0, 2, tg, wt);
    tick(); reset = 1;
    #3;
    chk("mid_rst_strobe", mem_read_en, 1'b0);
    tick(); reset = 0;
    #3;
    chk("post_rst_strobe", mem_read_en, 1'b0);
    chk("post_rst_done", m1_done, 1'b0);
    chk("post_rst_rdata", m1_rdata, 32'h0);
    repeat (12) tick();
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
    m0_addr = 32'h10; m1_addr = 32'h20; m0_width = 2; m1_width = 2; ws = 0;
    #3;
    chk("tie_m0_gnt", m0_gnt, 1'b1);
    chk("tie_m1_gnt", m1_gnt, 1'b0);
    tick(); m0_req = 0; m1_req = 0;
    repeat (4) tick();

    // Spurious acks in IDLE are ignored; done follows the real ack by one cycle.
    spur = 1; repeat (2) tick(); spur = 0;
    ws = 3; din_v = 32'hCAFEF00D;
    issue(0, 0, 32'h500, 0, 2, tg, wt);
    run_to_done(0, tg, n, d, e, rd);
    chk("spur_strobes", n, 4);
    chk("spur_latency", d, 5);
    chk("spur_err", e, 1'b0);
    chk("spur_rdata", rd, 32'hCAFEF00D);

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter and transaction sequencer for the single shared memory port. It sits between the core's memory bus (master 0) and a second master such as a program loader or debug port (master 1) on one side, and a variable-latency memory with an acknowledge on the other. It accepts one request at a time using round-robin arbitration and latches the request. It then holds the memory strobes until the memory acknowledges or a watchdog expires, and returns a one-cycle completion pulse with read data and an error flag.

## Interface
- TIMEOUT, 255: maximum cycles in ACCESS without `mem_ack` before the transaction is aborted with an error. A value of 0 disables the watchdog.
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  reset, synchronous, active-high; clock clk
- mN_req  in  1  request from master N (N = 0, 1); held until `mN_gnt`
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  32  byte address
- mN_wdata  in  32  write data, LSB-aligned
- mN_width  in  2  access width: 0 = byte, 1 = half, 2 = word, 3 = reserved
- mN_gnt  out  1  request accepted this cycle; the master may change or drop its inputs from the next cycle
- mN_done  out  1  one-cycle completion pulse
- mN_err  out  1  valid with `mN_done`: misaligned access, reserved width, or timeout
- mN_rdata  out  32  read data; updated when `mN_done` is asserted for a read, held otherwise
- mem_addr  out  32  memory address
- mem_dout  out  32  write data to memory
- mem_read_en  out  1  read strobe
- mem_write_en  out  1  write strobe
- mem_width  out  2  width to memory (0/1/2)
- mem_din  in  32  read data from memory; sampled in the cycle `mem_ack` is high
- mem_ack  in  1  memory completion; ignored outside ACCESS

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no `mN_req` is high, stay in IDLE.
  - If only one master requests, that master wins.
  - If both request, grant the master that is not `last_grant`.
  - `mN_gnt` is a combinational pulse for the winner in this cycle.
  - On the edge: latch we/addr/wdata/width, record the winner in `owner`, and set `last_grant` to the winner.
- Legality check, done on the latched values:
  - Width 3 is illegal.
  - Half access with addr[0] = 1 is illegal.
  - Word access with addr[1:0] != 0 is illegal.
  - An illegal request goes IDLE → RESP with err = 1 and never touches memory.
  - A legal request goes IDLE → ACCESS and clears the timeout counter.
- ACCESS:
  - `mem_addr`, `mem_dout` and `mem_width` carry the latched values.
  - `mem_read_en` = !we and `mem_write_en` = we.
  - The counter increments every cycle that `mem_ack` is low.
  - `mem_ack` high: capture `mem_din` (reads only), err = 0, go to RESP.
  - Counter equals TIMEOUT with `mem_ack` low (TIMEOUT ≠ 0): err = 1, go to RESP; `rdata` is not updated.
  - `mem_ack` high in the same cycle the counter equals TIMEOUT: `mem_ack` wins and the transfer succeeds.
- RESP:
  - `m[owner]_done` = 1 and `m[owner]_err` = latched err.
  - `m[owner]_rdata` shows the captured data (reads).
  - Next state is IDLE.
- Outside ACCESS, all `mem_*` outputs are 0.
- The counter width is enough to hold TIMEOUT; the counter saturates and does not wrap.
- Reset:
  - State → IDLE, `last_grant` = 1 (so master 0 wins the first tie), counter = 0, both `rdata` = 0.
  - All `gnt`/`done`/`err`/`mem_*` outputs are 0.
  - Reset in the middle of a transaction abandons it silently: no `done` pulse.

## Timing
- Request accepted in cycle T (`gnt` high in T).
- Legal access: strobes are asserted from T+1. With `mem_ack` first seen high in cycle A, `done` is asserted in A+1 and the FSM is back in IDLE at A+2.
- Zero-wait memory (`mem_ack` high in T+1): `done` in T+2. Back-to-back throughput is one access per 3 cycles.
- Illegal access: `done` with `err` in T+1.
- Timeout: the strobes stay high for TIMEOUT+1 cycles (T+1 … T+TIMEOUT+1), then `done` with `err` in T+TIMEOUT+2.
- A new request is not considered until IDLE. A request held high through a busy period is granted in the first IDLE cycle.
- `mN_rdata` is stable from the `done` cycle until that master's next read completes.
- A `mem_ack` arriving in IDLE or RESP has no effect.

## Test plan
- m0 read, width 2, addr 0x100, `mem_ack` in T+1, `mem_din` = 0xDEADBEEF → `m0_gnt` @T, `mem_read_en` @T+1, `m0_done` @T+2 with err 0, `m0_rdata` = 0xDEADBEEF; m1 outputs stay 0.
- Both masters request continuously after reset (m0 write, m1 read) → grants alternate m0, m1, m0, …; each `done` goes to the correct master only.
- m1 write, width 1, addr 0x203 → no `mem_*` strobe, `m1_done` and `m1_err` @T+1. A width 3 request gives the same response.
- TIMEOUT = 4, `mem_ack` never asserted → `mem_write_en` high for 5 cycles, `done` + `err` @T+6, `rdata` unchanged. Repeat with `mem_ack` on exactly the 5th strobe cycle → `done`, err 0.
- Reset asserted in ACCESS with wait states → next cycle all outputs 0, no `done`. Next tie after release goes to m0.
- Spurious `mem_ack` in IDLE, then m0 read with 3 wait states → the spurious ack is ignored and `done` comes 1 cycle after the real ack.
